mvm_ingress_decoder: RTL and testbench
======================================

MVM_INGRESS_DECODER -- requirements
Module: mvm_ingress_decoder

Interface
REQ-001 Parameter LOCAL_DEST, default 12'h001: NoC destination address of this node; beats addressed elsewhere are dropped.
REQ-002 Parameter NROWS, default 64: register-file depth, equal to the one-hot row-select field width (USERW-11).
REQ-003 CLK  in  1  sole clock; all state on rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 AXIS_S_TVALID/TREADY  in/out  1/1  AXI-Stream slave handshake.
REQ-006 AXIS_S_TDATA  in  DATAW  payload word.
REQ-007 AXIS_S_TUSER  in  USERW  [8:0] RF id, [10:9] opcode, [USERW-1:11] one-hot row select.
REQ-008 AXIS_S_TDEST/TID/TLAST  in  DESTW/IDW/1  destination, id (ignored), packet end.
REQ-009 RF_WEN/RF_WADDR/RF_WDATA/RF_WID  out  1/log2(NROWS)/DATAW/9  registered register-file write port.
REQ-010 VEC_VALID/VEC_READY/VEC_DATA  out/in/out  1/1/DATAW  input-vector handoff to compute engine.
REQ-011 RF_LOADED  out  1  every row written since last clear.
REQ-012 ERR_ONEHOT  out  1  sticky malformed-row-select flag.
REQ-013 DROP_CNT/PKT_CNT  out  16/16  saturating dropped-beat and accepted-TLAST counters.

Function
REQ-014 Handshake: beat accepted on rising edge with TVALID&&TREADY; TREADY = !(VEC_VALID && !VEC_READY), and SHALL be 0 while RST_N low.
REQ-015 Each beat self-contained; TLAST only increments PKT_CNT (saturating at 16'hFFFF).
REQ-016 Opcode 2'b11 WRITE_RF: TDEST==LOCAL_DEST and row field one-hot -> RF_WEN=1 for exactly the following cycle, RF_WADDR=index of set bit, RF_WDATA=TDATA, RF_WID=TUSER[8:0]; row bit set in loaded mask.
REQ-017 WRITE_RF with zero or multiple row bits set: no write, ERR_ONEHOT set until reset.
REQ-018 Opcode 2'b10 LOAD_VEC: VEC_VALID=1 and VEC_DATA=TDATA from the following cycle, held stable until VEC_READY sampled high; row field ignored.
REQ-019 Opcode 2'b01 CLEAR: clears loaded mask (RF_LOADED=0 next cycle); no RF write.
REQ-020 Opcode 2'b00 NOP: accepted, no effect beyond PKT_CNT.
REQ-021 TDEST!=LOCAL_DEST: accepted, discarded, DROP_CNT+1 (saturating), no other effect.
REQ-022 Output FSM states IDLE, WRITE (1 cycle), VEC_HOLD; IDLE->WRITE on valid WRITE_RF, IDLE/WRITE->VEC_HOLD on LOAD_VEC, VEC_HOLD->IDLE on VEC_READY without new beat, VEC_HOLD->VEC_HOLD on VEC_READY with concurrent new LOAD_VEC, WRITE->IDLE otherwise.
REQ-023 Back-to-back WRITE_RF beats SHALL sustain one write per cycle.
REQ-024 VEC_READY and new beat in same cycle: old vector retires, new beat processed, no bubble.
REQ-025 RF_LOADED = AND of all NROWS mask bits, registered; rewriting a row keeps it set.
REQ-026 CLEAR and WRITE_RF never coincide (one beat/cycle); a write after CLEAR sets only its row.

Reset
REQ-027 RST_N low: RF_WEN=0, RF_WADDR=0, RF_WDATA=0, RF_WID=0, VEC_VALID=0, VEC_DATA=0, RF_LOADED=0, ERR_ONEHOT=0, DROP_CNT=0, PKT_CNT=0, mask=0, FSM=IDLE, TREADY=0.
REQ-028 Reset mid-VEC_HOLD discards pending vector; first beat after release treated as fresh.

Structure
REQ-029 Opcode enum (NOP, CLEAR, LOAD_VEC, WRITE_RF) and TUSER field offsets SHALL live in the shared parameters package with DATAW/USERW/DESTW/IDW.
REQ-030 One sub-module onehot_enc: NROWS-bit one-hot in -> index plus valid (exactly one bit set), combinational.

Verification
REQ-031 WRITE_RF, TDEST=12'h001, row bit 0, TDATA=0xA5 -> next cycle RF_WEN=1, RF_WADDR=0, RF_WDATA=0xA5, RF_WID=9'h001.
REQ-032 64 back-to-back WRITE_RF rows 0..63 -> 64 consecutive RF_WEN cycles, RF_LOADED=1 one cycle after last; CLEAR -> RF_LOADED=0.
REQ-033 LOAD_VEC 0x1234 with VEC_READY=0 for 5 cycles -> VEC_VALID held, VEC_DATA stable, TREADY=0; VEC_READY=1 -> retires, TREADY=1.
REQ-034 WRITE_RF rows {0,1} set -> no RF_WEN, ERR_ONEHOT=1 until reset; TDEST=12'h002 -> DROP_CNT=1, no write.
REQ-035 Assert RST_N=0 while VEC_VALID=1 -> all outputs zero immediately; after release, TREADY=1 and no stale vector.

Source files
------------

// File: rtl/mvm_ingress_decoder_pkg.sv
// ============================================================================
// Module  : mvm_ingress_decoder_pkg
// Brief   : Shared widths, TUSER field offsets and opcode encoding for the decoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mvm_ingress_decoder_pkg;

   localparam int DATAW     = 32;
   localparam int DESTW     = 12;
   localparam int IDW       = 4;
   localparam int NROWS_DEF = 64;
   localparam int USERW     = NROWS_DEF + 11;

   // TUSER layout: {row_onehot, opcode, rf_id}
   localparam int RFID_LSB = 0;
   localparam int RFID_W   = 9;
   localparam int OP_LSB   = 9;
   localparam int OP_W     = 2;
   localparam int ROW_LSB  = 11;

   typedef enum logic [1:0] {
      OP_NOP      = 2'b00,
      OP_CLEAR    = 2'b01,
      OP_LOAD_VEC = 2'b10,
      OP_WRITE_RF = 2'b11
   } opcode_e;

endpackage

`default_nettype wire

// File: rtl/mvm_ingress_decoder_onehot_enc.sv
// ============================================================================
// Module  : onehot_enc
// Brief   : Combinational one-hot to binary index; valid only when exactly one bit is set.
// Revision: 1.0
// ============================================================================
`default_nettype none

module onehot_enc #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0]         i_onehot,
   output logic [$clog2(WIDTH)-1:0] o_index,
   output logic                     o_valid
);

   localparam int IDXW = $clog2(WIDTH);

   logic [IDXW-1:0] w_idx;
   logic            w_seen;
   logic            w_multi;

   always_comb begin
      w_idx   = '0;
      w_seen  = 1'b0;
      w_multi = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i_onehot[i]) begin
            w_idx   = w_idx | IDXW'(i);
            w_multi = w_multi | w_seen;
            w_seen  = 1'b1;
         end
      end
   end

   assign o_index = w_idx;
   assign o_valid = w_seen & ~w_multi;

endmodule

`default_nettype wire

// File: rtl/mvm_ingress_decoder.sv
// ============================================================================
// Module  : mvm_ingress_decoder
// Brief   : AXI-Stream ingress decoder feeding a register file and a vector handoff port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mvm_ingress_decoder
   import mvm_ingress_decoder_pkg::*;
#(
   parameter logic [DESTW-1:0] LOCAL_DEST = 12'h001,
   parameter int               NROWS      = NROWS_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_axis_s_tvalid,
   output logic                     o_axis_s_tready,
   input  logic [DATAW-1:0]         i_axis_s_tdata,
   input  logic [USERW-1:0]         i_axis_s_tuser,
   input  logic [DESTW-1:0]         i_axis_s_tdest,
   input  logic [IDW-1:0]           i_axis_s_tid,
   input  logic                     i_axis_s_tlast,
   output logic                     o_rf_wen,
   output logic [$clog2(NROWS)-1:0] o_rf_waddr,
   output logic [DATAW-1:0]         o_rf_wdata,
   output logic [RFID_W-1:0]        o_rf_wid,
   output logic                     o_vec_valid,
   input  logic                     i_vec_ready,
   output logic [DATAW-1:0]         o_vec_data,
   output logic                     o_rf_loaded,
   output logic                     o_err_onehot,
   output logic [15:0]              o_drop_cnt,
   output logic [15:0]              o_pkt_cnt
);

   localparam int ADDRW = $clog2(NROWS);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WRITE    = 2'd1,
      S_VEC_HOLD = 2'd2
   } state_e;

   state_e              r_state;
   state_e              w_state_next;
   logic [NROWS-1:0]    r_mask;
   logic [NROWS-1:0]    w_mask_next;
   logic [ADDRW-1:0]    r_waddr;
   logic [DATAW-1:0]    r_wdata;
   logic [RFID_W-1:0]   r_wid;
   logic [DATAW-1:0]    r_vec_data;
   logic                r_loaded;
   logic                r_err;
   logic [15:0]         r_drop_cnt;
   logic [15:0]         r_pkt_cnt;

   logic                w_tready;
   logic                w_accept;
   logic                w_local;
   logic                w_beat;
   opcode_e             w_op;
   logic [NROWS-1:0]    w_rowsel;
   logic [ADDRW-1:0]    w_row_idx;
   logic                w_row_ok;
   logic                w_do_write;
   logic                w_do_load;
   logic                w_do_clear;
   logic                w_bad_row;
   logic                w_unused_tid;

   assign w_unused_tid = ^i_axis_s_tid;

   // A held vector blocks intake unless it is retiring this very cycle.
   assign w_tready   = rst_n & ~((r_state == S_VEC_HOLD) & ~i_vec_ready);
   assign w_accept   = i_axis_s_tvalid & w_tready;
   assign w_local    = (i_axis_s_tdest == LOCAL_DEST);
   assign w_beat     = w_accept & w_local;
   assign w_op       = opcode_e'(i_axis_s_tuser[OP_LSB +: OP_W]);
   assign w_rowsel   = i_axis_s_tuser[ROW_LSB +: NROWS];

   onehot_enc #(.WIDTH(NROWS)) u_onehot_enc (
      .i_onehot (w_rowsel),
      .o_index  (w_row_idx),
      .o_valid  (w_row_ok)
   );

   assign w_do_write = w_beat & (w_op == OP_WRITE_RF) & w_row_ok;
   assign w_bad_row  = w_beat & (w_op == OP_WRITE_RF) & ~w_row_ok;
   assign w_do_load  = w_beat & (w_op == OP_LOAD_VEC);
   assign w_do_clear = w_beat & (w_op == OP_CLEAR);

   always_comb begin
      w_state_next = S_IDLE;
      w_mask_next  = r_mask;
      if (w_do_write) begin
         w_state_next = S_WRITE;
      end else if (w_do_load) begin
         w_state_next = S_VEC_HOLD;
      end else if ((r_state == S_VEC_HOLD) && !i_vec_ready) begin
         w_state_next = S_VEC_HOLD;
      end
      if (w_do_clear) begin
         w_mask_next = '0;
      end else if (w_do_write) begin
         w_mask_next = r_mask | w_rowsel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask     <= '0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_wid      <= '0;
         r_vec_data <= '0;
         r_loaded   <= 1'b0;
         r_err      <= 1'b0;
         r_drop_cnt <= '0;
         r_pkt_cnt  <= '0;
      end else begin
         r_mask   <= w_mask_next;
         r_loaded <= &w_mask_next;
         if (w_do_write) begin
            r_waddr <= w_row_idx;
            r_wdata <= i_axis_s_tdata;
            r_wid   <= i_axis_s_tuser[RFID_LSB +: RFID_W];
         end
         if (w_do_load) begin
            r_vec_data <= i_axis_s_tdata;
         end
         if (w_bad_row) begin
            r_err <= 1'b1;
         end
         if (w_accept && !w_local && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end
         if (w_beat && i_axis_s_tlast && (r_pkt_cnt != 16'hFFFF)) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
         end
      end
   end

   assign o_axis_s_tready = w_tready;
   assign o_rf_wen        = (r_state == S_WRITE);
   assign o_rf_waddr      = r_waddr;
   assign o_rf_wdata      = r_wdata;
   assign o_rf_wid        = r_wid;
   assign o_vec_valid     = (r_state == S_VEC_HOLD);
   assign o_vec_data      = r_vec_data;
   assign o_rf_loaded     = r_loaded;
   assign o_err_onehot    = r_err;
   assign o_drop_cnt      = r_drop_cnt;
   assign o_pkt_cnt       = r_pkt_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mvm_ingress_decoder.sv
// ============================================================================
// Module  : tb_mvm_ingress_decoder
// Brief   : Self-checking bench: behavioural beat model plus directed literal checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mvm_ingress_decoder;
   import mvm_ingress_decoder_pkg::*;

   localparam logic [11:0] LD = 12'h001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tvalid;
   logic        tready;
   logic [31:0] tdata;
   logic [74:0] tuser;
   logic [11:0] tdest;
   logic [3:0]  tid;
   logic        tlast;
   logic        wen;
   logic [5:0]  waddr;
   logic [31:0] wdata;
   logic [8:0]  wid;
   logic        vvalid;
   logic        vec_ready;
   logic [31:0] vdata;
   logic        loaded;
   logic        err;
   logic [15:0] drop_cnt;
   logic [15:0] pkt_cnt;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mvm_ingress_decoder #(.LOCAL_DEST(12'h001), .NROWS(64)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_axis_s_tvalid (tvalid),
      .o_axis_s_tready (tready),
      .i_axis_s_tdata  (tdata),
      .i_axis_s_tuser  (tuser),
      .i_axis_s_tdest  (tdest),
      .i_axis_s_tid    (tid),
      .i_axis_s_tlast  (tlast),
      .o_rf_wen        (wen),
      .o_rf_waddr      (waddr),
      .o_rf_wdata      (wdata),
      .o_rf_wid        (wid),
      .o_vec_valid     (vvalid),
      .i_vec_ready     (vec_ready),
      .o_vec_data      (vdata),
      .o_rf_loaded     (loaded),
      .o_err_onehot    (err),
      .o_drop_cnt      (drop_cnt),
      .o_pkt_cnt       (pkt_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Behavioural model: outputs follow from the last accepted beat's meaning.
   logic        m_wen = 0;
   logic [5:0]  m_waddr = 0;
   logic [31:0] m_wdata = 0;
   logic [8:0]  m_wid = 0;
   logic        m_vvalid = 0;
   logic [31:0] m_vdata = 0;
   logic [63:0] m_mask = 0;
   logic        m_loaded = 0;
   logic        m_err = 0;
   logic [15:0] m_drop = 0;
   logic [15:0] m_pkt = 0;
   logic        m_rdy;
   logic [63:0] m_rows;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wen = 0; m_waddr = 0; m_wdata = 0; m_wid = 0; m_vvalid = 0; m_vdata = 0;
         m_mask = 0; m_loaded = 0; m_err = 0; m_drop = 0; m_pkt = 0;
      end else begin
         m_rdy  = !(m_vvalid && !vec_ready);
         m_rows = tuser[74:11];
         m_wen  = 0;
         if (m_vvalid && vec_ready) m_vvalid = 0;
         if (tvalid && m_rdy) begin
            if (tdest != LD) begin
               if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
            end else begin
               if (tlast && m_pkt != 16'hFFFF) m_pkt = m_pkt + 1;
               case (tuser[10:9])
                  2'b11: begin
                     if ($countones(m_rows) == 1) begin
                        m_wen = 1;
                        for (int i = 0; i < 64; i++) if (m_rows[i]) m_waddr = 6'(i);
                        m_wdata = tdata;
                        m_wid   = tuser[8:0];
                        m_mask  = m_mask | m_rows;
                     end else begin
                        m_err = 1;
                     end
                  end
                  2'b10: begin m_vvalid = 1; m_vdata = tdata; end
                  2'b01: m_mask = 0;
                  default: ;
               endcase
            end
         end
         m_loaded = ($countones(m_mask) == 64);
      end
   end

   always @(negedge clk) begin
      chk("m_tready", 64'(tready), 64'(rst_n && !(m_vvalid && !vec_ready)));
      chk("m_wen", 64'(wen), 64'(m_wen));
      chk("m_vvalid", 64'(vvalid), 64'(m_vvalid));
      chk("m_loaded", 64'(loaded), 64'(m_loaded));
      chk("m_err", 64'(err), 64'(m_err));
      chk("m_drop", 64'(drop_cnt), 64'(m_drop));
      chk("m_pkt", 64'(pkt_cnt), 64'(m_pkt));
      if (m_wen) begin
         chk("m_waddr", 64'(waddr), 64'(m_waddr));
         chk("m_wdata", 64'(wdata), 64'(m_wdata));
         chk("m_wid", 64'(wid), 64'(m_wid));
      end
      if (m_vvalid) chk("m_vdata", 64'(vdata), 64'(m_vdata));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat and returns just after the edge that accepted it.
   task automatic send(input logic [1:0] op, input logic [63:0] rows, input logic [31:0] data,
                       input logic [11:0] dest, input logic [8:0] rfid, input logic last);
      logic rdy;
      logic done;
      tvalid = 1; tdata = data; tuser = {rows, op, rfid}; tdest = dest; tlast = last;
      done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         #1;
         rdy = tready;
         step();
         done = rdy;
      end
      if (!done) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic idle();
      tvalid = 0; tlast = 0;
      step();
   endtask

   initial begin
      rst_n = 1; tvalid = 0; tdata = 0; tuser = 0; tdest = LD; tid = 4'h3; tlast = 0; vec_ready = 1;
      #2 rst_n = 0;
      repeat (3) step();
      chk("rst_tready", 64'(tready), 64'd0);
      chk("rst_wen", 64'(wen), 64'd0);
      chk("rst_waddr", 64'(waddr), 64'd0);
      chk("rst_wdata", 64'(wdata), 64'd0);
      chk("rst_wid", 64'(wid), 64'd0);
      chk("rst_vvalid", 64'(vvalid), 64'd0);
      chk("rst_vdata", 64'(vdata), 64'd0);
      chk("rst_loaded", 64'(loaded), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_cnts", 64'({drop_cnt, pkt_cnt}), 64'd0);
      rst_n = 1;
      step();

      send(OP_WRITE_RF, 64'h1, 32'hA5, LD, 9'h001, 0);
      chk("w0_wen", 64'(wen), 64'd1);
      chk("w0_waddr", 64'(waddr), 64'd0);
      chk("w0_wdata", 64'(wdata), 64'hA5);
      chk("w0_wid", 64'(wid), 64'h001);
      idle();

      for (int i = 0; i < 64; i++) begin
         send(OP_WRITE_RF, 64'd1 << i, 32'(i * 3 + 7), LD, 9'(i + 2), i == 63);
         chk("b2b_wen", 64'(wen), 64'd1);
         if (i == 62) chk("b2b_loaded62", 64'(loaded), 64'd0);
         if (i == 63) begin
            chk("b2b_waddr63", 64'(waddr), 64'd63);
            chk("b2b_wdata63", 64'(wdata), 64'd196);
            chk("b2b_loaded63", 64'(loaded), 64'd1);
         end
      end
      idle();
      chk("loaded_hold", 64'(loaded), 64'd1);
      chk("pkt_after_b2b", 64'(pkt_cnt), 64'd1);
      send(OP_CLEAR, 64'h0, 32'h0, LD, 9'h0, 1);
      chk("clear_loaded", 64'(loaded), 64'd0);
      chk("clear_wen", 64'(wen), 64'd0);
      chk("clear_pkt", 64'(pkt_cnt), 64'd2);
      send(OP_WRITE_RF, 64'h20, 32'h55, LD, 9'h0, 0);
      chk("post_clear_loaded", 64'(loaded), 64'd0);
      idle();

      vec_ready = 0;
      send(OP_LOAD_VEC, 64'hFFFF, 32'h1234, LD, 9'h0, 0);
      tvalid = 0;
      for (int k = 0; k < 5; k++) begin
         chk("hold_vvalid", 64'(vvalid), 64'd1);
         chk("hold_vdata", 64'(vdata), 64'h1234);
         chk("hold_tready", 64'(tready), 64'd0);
         step();
      end
      vec_ready = 1;
      #1;
      chk("retire_tready", 64'(tready), 64'd1);
      step();
      chk("retire_vvalid", 64'(vvalid), 64'd0);

      vec_ready = 0;
      send(OP_LOAD_VEC, 64'h0, 32'hAAAA, LD, 9'h0, 0);
      vec_ready = 1;
      send(OP_LOAD_VEC, 64'h0, 32'hBBBB, LD, 9'h0, 0);
      chk("b2b_vec_valid", 64'(vvalid), 64'd1);
      chk("b2b_vec_data", 64'(vdata), 64'hBBBB);
      send(OP_WRITE_RF, 64'h80, 32'h77, LD, 9'h0, 0);
      chk("vec_then_write_vvalid", 64'(vvalid), 64'd0);
      chk("vec_then_write_wen", 64'(wen), 64'd1);
      chk("vec_then_write_waddr", 64'(waddr), 64'd7);
      idle();

      send(OP_WRITE_RF, 64'h3, 32'h99, LD, 9'h0, 0);
      chk("multi_wen", 64'(wen), 64'd0);
      chk("multi_err", 64'(err), 64'd1);
      send(OP_WRITE_RF, 64'h0, 32'h98, LD, 9'h0, 0);
      chk("zero_wen", 64'(wen), 64'd0);
      send(OP_WRITE_RF, 64'h200, 32'h97, 12'h002, 9'h0, 0);
      chk("drop_cnt", 64'(drop_cnt), 64'd1);
      chk("drop_wen", 64'(wen), 64'd0);
      send(OP_NOP, 64'h1, 32'h0, LD, 9'h0, 1);
      chk("nop_pkt", 64'(pkt_cnt), 64'd3);
      chk("nop_wen", 64'(wen), 64'd0);
      idle();
      chk("err_sticky", 64'(err), 64'd1);

      vec_ready = 0;
      send(OP_LOAD_VEC, 64'h0, 32'h5555, LD, 9'h0, 0);
      tvalid = 0;
      chk("pre_rst_vvalid", 64'(vvalid), 64'd1);
      rst_n = 0;
      #1;
      chk("arst_vvalid", 64'(vvalid), 64'd0);
      chk("arst_vdata", 64'(vdata), 64'd0);
      chk("arst_tready", 64'(tready), 64'd0);
      chk("arst_err", 64'(err), 64'd0);
      chk("arst_cnts", 64'({drop_cnt, pkt_cnt}), 64'd0);
      chk("arst_wen", 64'(wen), 64'd0);
      step();
      rst_n = 1;
      step();
      chk("post_rst_tready", 64'(tready), 64'd1);
      chk("post_rst_vvalid", 64'(vvalid), 64'd0);
      send(OP_WRITE_RF, 64'h4, 32'hC3, LD, 9'h011, 0);
      chk("fresh_wen", 64'(wen), 64'd1);
      chk("fresh_waddr", 64'(waddr), 64'd2);
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
